// File: rtl/year_leap_counter_if.sv
// Date/year bus between the calendar controller and the BCD year register.
// The master drives the day tick, current date and load request; the slave returns the year and leap code.
interface year_leap_counter_if;
  logic        en;
  logic [3:0]  month1;
  logic [3:0]  month0;
  logic [3:0]  day1;
  logic [3:0]  day0;
  logic        load;
  logic [15:0] year_in;
  logic [3:0]  year3;
  logic [3:0]  year2;
  logic [3:0]  year1;
  logic [3:0]  year0;
  logic [1:0]  leap_en;
  logic        year_inc;
  logic        load_err;

  modport master (
    output en, month1, month0, day1, day0, load, year_in,
    input  year3, year2, year1, year0, leap_en, year_inc, load_err
  );

  modport slave (
    input  en, month1, month0, day1, day0, load, year_in,
    output year3, year2, year1, year0, leap_en, year_inc, load_err
  );
endinterface

// File: rtl/year_leap_counter.sv
// Four-digit BCD year register advanced on the 12/31 -> 01/01 rollover.
// Also produces the leap code consumed by the month/date counter (00 = leap).
module year_leap_counter #(
  parameter logic [15:0] RST_YEAR = 16'h2015
) (
  input  logic              clk_i,
  input  logic              rst_n,
  year_leap_counter_if.slave bus
);

  logic [15:0] year_q;
  logic [1:0]  leap_q;
  logic        inc_q;
  logic        err_q;

  logic [15:0] year_d;
  logic        upd;
  logic        inc_d;
  logic        err_d;
  logic        last_day;

  function automatic logic pair_div4(input logic [3:0] d1, input logic [3:0] d0);
    if (!d1[0])
      return (d0 == 4'd0) || (d0 == 4'd4) || (d0 == 4'd8);
    else
      return (d0 == 4'd2) || (d0 == 4'd6);
  endfunction

  function automatic logic [1:0] leap_code(input logic [15:0] y);
    if (y[7:0] != 8'h00)
      return pair_div4(y[7:4], y[3:0]) ? 2'b00 : 2'b01;
    else
      return pair_div4(y[15:12], y[11:8]) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic bcd_valid(input logic [15:0] y);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++)
      if (y[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Ripple the carry digit by digit; 9999 naturally wraps to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] y);
    logic [15:0] r;
    logic        carry;
    r     = y;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = '0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign last_day = (bus.month1 == 4'd1) && (bus.month0 == 4'd2) &&
                    (bus.day1 == 4'd3) && (bus.day0 == 4'd1);

  always_comb begin
    year_d = year_q;
    upd    = 1'b0;
    inc_d  = 1'b0;
    err_d  = 1'b0;
    if (bus.load) begin
      if (bcd_valid(bus.year_in)) begin
        year_d = bus.year_in;
        upd    = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en && last_day) begin
      year_d = bcd_inc(year_q);
      upd    = 1'b1;
      inc_d  = 1'b1;
    end
  end

  // Year and leap code load from the same next-year value so they never disagree.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      year_q <= RST_YEAR;
      leap_q <= leap_code(RST_YEAR);
      inc_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (upd) begin
        year_q <= year_d;
        leap_q <= leap_code(year_d);
      end
      inc_q <= inc_d;
      err_q <= err_d;
    end
  end

  assign bus.year3    = year_q[15:12];
  assign bus.year2    = year_q[11:8];
  assign bus.year1    = year_q[7:4];
  assign bus.year0    = year_q[3:0];
  assign bus.leap_en  = leap_q;
  assign bus.year_inc = inc_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_year_leap_counter.sv
// Directed bench for year_leap_counter: rollover, leap codes, loads, reset.
module tb_year_leap_counter;

  logic clk_i;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  year_leap_counter_if bus ();

  year_leap_counter #(.RST_YEAR(16'h2015)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_date(input logic [3:0] m1, input logic [3:0] m0,
                          input logic [3:0] d1, input logic [3:0] d0, input logic e);
    bus.month1 = m1;
    bus.month0 = m0;
    bus.day1   = d1;
    bus.day0   = d0;
    bus.en     = e;
  endtask

  task automatic idle();
    bus.en   = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [15:0] y, input logic [1:0] l,
                              input logic inc, input logic err);
    check({tag, ".year"}, {16'h0, bus.year3, bus.year2, bus.year1, bus.year0}, {16'h0, y});
    check({tag, ".leap"}, {30'h0, bus.leap_en}, {30'h0, l});
    check({tag, ".inc"},  {31'h0, bus.year_inc}, {31'h0, inc});
    check({tag, ".err"},  {31'h0, bus.load_err}, {31'h0, err});
  endtask

  task automatic do_load(input logic [15:0] y);
    bus.load    = 1'b1;
    bus.year_in = y;
    bus.en      = 1'b0;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic roll();
    set_date(4'd1, 4'd2, 4'd3, 4'd1, 1'b1);
    tick();
    bus.en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    bus.year_in = 16'h0000;
    set_date(4'd0, 4'd1, 4'd0, 4'd1, 1'b0);
    #12;
    expect_state("reset", 16'h2015, 2'b01, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    set_date(4'd1, 4'd2, 4'd3, 4'd0, 1'b1);
    tick(); tick();
    expect_state("dec30", 16'h2015, 2'b01, 1'b0, 1'b0);

    roll();
    expect_state("to2016", 16'h2016, 2'b00, 1'b1, 1'b0);
    tick();
    expect_state("inc_drop", 16'h2016, 2'b00, 1'b0, 1'b0);

    do_load(16'h2099);
    expect_state("ld2099", 16'h2099, 2'b01, 1'b0, 1'b0);
    roll();
    expect_state("to2100", 16'h2100, 2'b10, 1'b1, 1'b0);

    do_load(16'h2399);
    roll();
    expect_state("to2400", 16'h2400, 2'b00, 1'b1, 1'b0);

    do_load(16'h1896);
    expect_state("ld1896", 16'h1896, 2'b00, 1'b0, 1'b0);

    do_load(16'h9999);
    expect_state("ld9999", 16'h9999, 2'b01, 1'b0, 1'b0);
    roll();
    expect_state("wrap", 16'h0000, 2'b00, 1'b1, 1'b0);

    do_load(16'h20A5);
    expect_state("badld", 16'h0000, 2'b00, 1'b0, 1'b1);
    tick();
    expect_state("badld_end", 16'h0000, 2'b00, 1'b0, 1'b0);

    set_date(4'd1, 4'd2, 4'd3, 4'd1, 1'b1);
    bus.load    = 1'b1;
    bus.year_in = 16'h2028;
    tick();
    idle();
    expect_state("ld_vs_inc", 16'h2028, 2'b00, 1'b0, 1'b0);

    set_date(4'd1, 4'd2, 4'd3, 4'd1, 1'b0);
    tick();
    expect_state("en_low", 16'h2028, 2'b00, 1'b0, 1'b0);

    set_date(4'd0, 4'd2, 4'd2, 4'd9, 1'b1);
    tick();
    expect_state("feb29", 16'h2028, 2'b00, 1'b0, 1'b0);

    set_date(4'd1, 4'd2, 4'd3, 4'd1, 1'b1);
    tick();
    expect_state("b2b_1", 16'h2029, 2'b01, 1'b1, 1'b0);
    tick();
    expect_state("b2b_2", 16'h2030, 2'b01, 1'b1, 1'b0);
    bus.en = 1'b0;

    do_load(16'h2399);
    roll();
    expect_state("pre_rst", 16'h2400, 2'b00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 16'h2015, 2'b01, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_state("post_rst", 16'h2015, 2'b01, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
